// File: rtl/ex_md_pkg.sv
// rtl/ex_md_pkg.sv - shared types and encodings for the M-extension execute stage
package ex_md_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } mdop_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    // Bit positions within mdop_t: bit 2 selects divide, bit 1 (with bit 2) selects remainder.
    localparam int MDOP_IS_DIV = 2;
    localparam int MDOP_IS_REM = 1;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

endpackage

// File: rtl/ex_stage_md_alu.sv
// rtl/ex_stage_md_alu.sv - single-cycle integer ALU
module ex_stage_md_alu
    import ex_md_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] res_o
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    logic [SH_W-1:0] shamt;
    assign shamt = b_i[SH_W-1:0];

    always_comb begin
        res_o = '0;
        case (op_i)
            ALU_ADD:  res_o = a_i + b_i;
            ALU_SUB:  res_o = a_i - b_i;
            ALU_SLL:  res_o = a_i << shamt;
            ALU_SLT:  res_o = DATA_WIDTH'($signed(a_i) < $signed(b_i));
            ALU_SLTU: res_o = DATA_WIDTH'(a_i < b_i);
            ALU_XOR:  res_o = a_i ^ b_i;
            ALU_SRL:  res_o = a_i >> shamt;
            ALU_SRA:  res_o = $signed(a_i) >>> shamt;
            ALU_OR:   res_o = a_i | b_i;
            ALU_AND:  res_o = a_i & b_i;
            default:  res_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage_md_muldiv.sv
// rtl/ex_stage_md_muldiv.sv - multi-cycle RV32M multiply / restoring divide unit
module muldiv_unit
    import ex_md_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int W       = DATA_WIDTH;
    localparam int W2      = 2 * DATA_WIDTH;
    localparam int CNT_MAX = (DATA_WIDTH > MUL_LATENCY) ? DATA_WIDTH : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [W-1:0]     ma_q, ma_d;
    logic [W-1:0]     mb_q, mb_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     result_q, result_d;

    logic         is_div, is_rem, sign_a, sign_b, a_neg, b_neg, div_zero, div_ovf;
    logic [W-1:0] mag_a, mag_b, fast_res;

    assign is_div   = op_i[MDOP_IS_DIV];
    assign is_rem   = op_i[MDOP_IS_DIV] & op_i[MDOP_IS_REM];
    assign sign_a   = (op_i == MD_MULH) | (op_i == MD_MULHSU) | (op_i == MD_DIV) | (op_i == MD_REM);
    assign sign_b   = (op_i == MD_MULH) | (op_i == MD_DIV) | (op_i == MD_REM);
    assign a_neg    = sign_a & a_i[W-1];
    assign b_neg    = sign_b & b_i[W-1];
    assign mag_a    = a_neg ? -a_i : a_i;
    assign mag_b    = b_neg ? -b_i : b_i;
    assign div_zero = (b_i == '0);
    assign div_ovf  = sign_b & (a_i == MOST_NEG) & (&b_i);

    always_comb begin
        fast_res = '0;
        if (div_zero) fast_res = is_rem ? a_i : '1;
        else          fast_res = is_rem ? '0 : MOST_NEG;
    end

    // Multiply on magnitudes, then reapply the sign to the full double-width product.
    logic [W2-1:0] prod, prod_s;
    logic [W-1:0]  mul_res;
    assign prod    = W2'(ma_q) * W2'(mb_q);
    assign prod_s  = qneg_q ? -prod : prod;
    assign mul_res = (op_q == MD_MUL) ? prod_s[W-1:0] : prod_s[W2-1:W];

    // One restoring step: ma_q doubles as the dividend/quotient shift register.
    logic [W:0]   shifted;
    logic         fits;
    logic [W-1:0] rem_nx, quo_nx, div_res;
    assign shifted = {rem_q, ma_q[W-1]};
    assign fits    = (shifted >= {1'b0, mb_q});
    assign rem_nx  = fits ? (shifted[W-1:0] - mb_q) : shifted[W-1:0];
    assign quo_nx  = {ma_q[W-2:0], fits};
    assign div_res = (op_q[MDOP_IS_DIV] & op_q[MDOP_IS_REM])
                   ? (rneg_q ? -rem_nx : rem_nx)
                   : (qneg_q ? -quo_nx : quo_nx);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d   = op_i;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    ma_d   = mag_a;
                    mb_d   = mag_b;
                    rem_d  = '0;
                    if (is_div && (div_zero || div_ovf)) begin
                        result_d = fast_res;
                        state_d  = ST_DONE;
                    end else if (is_div) begin
                        cnt_d   = CNT_W'(W - 1);
                        state_d = ST_DIV;
                    end else begin
                        cnt_d   = CNT_W'(MUL_LATENCY - 1);
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    result_d = mul_res;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = rem_nx;
                    ma_d  = quo_nx;
                    if (cnt_q == '0) begin
                        result_d = div_res;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            ma_q     <= '0;
            mb_q     <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = ((state_q == ST_IDLE) & start_i)
                    | (((state_q == ST_MUL) | (state_q == ST_DIV)) & ~flush_i);
    assign done_o   = (state_q == ST_DONE) & ~flush_i;
    assign result_o = result_q;

endmodule

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - execute stage: forwarding, operand select, ALU and M-unit
module ex_stage_md
    import ex_md_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic                  flush_i,
    input  logic                  md_en_i,
    input  logic [3:0]            aluop_i,
    input  logic [2:0]            mdop_i,
    input  logic                  opr_a_sel_i,
    input  logic                  opr_b_sel_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic                  fwd_mem_en_i,
    input  logic                  fwd_wb_en_i,
    input  logic [REG_ADDR_W-1:0] fwd_mem_rd_i,
    input  logic [REG_ADDR_W-1:0] fwd_wb_rd_i,
    input  logic [DATA_WIDTH-1:0] fwd_mem_data_i,
    input  logic [DATA_WIDTH-1:0] fwd_wb_data_i,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  res_valid_o,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] rs2_fwd_o
);

    logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2, opr_a, opr_b, alu_res, md_res;
    logic                  md_start, md_busy, md_done;
    logic [REG_ADDR_W-1:0] rd_unused;

    // rd is carried by the pipeline register, not consumed here.
    assign rd_unused = rd_i;

    always_comb begin
        fwd_rs1 = rs1_data_i;
        if (fwd_mem_en_i && fwd_mem_rd_i == rs1_i && rs1_i != '0)     fwd_rs1 = fwd_mem_data_i;
        else if (fwd_wb_en_i && fwd_wb_rd_i == rs1_i && rs1_i != '0)  fwd_rs1 = fwd_wb_data_i;
    end

    always_comb begin
        fwd_rs2 = rs2_data_i;
        if (fwd_mem_en_i && fwd_mem_rd_i == rs2_i && rs2_i != '0)     fwd_rs2 = fwd_mem_data_i;
        else if (fwd_wb_en_i && fwd_wb_rd_i == rs2_i && rs2_i != '0)  fwd_rs2 = fwd_wb_data_i;
    end

    assign opr_a     = opr_a_sel_i ? pc_i : fwd_rs1;
    assign opr_b     = opr_b_sel_i ? imm_i : fwd_rs2;
    assign rs2_fwd_o = fwd_rs2;

    ex_stage_md_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op_i  (aluop_i),
        .a_i   (opr_a),
        .b_i   (opr_b),
        .res_o (alu_res)
    );

    // Gating with rst_n keeps stall/valid low for the whole time reset is held.
    assign md_start = rst_n & valid_i & md_en_i & ~flush_i;

    muldiv_unit #(.DATA_WIDTH(DATA_WIDTH), .MUL_LATENCY(MUL_LATENCY)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (md_start),
        .op_i     (mdop_i),
        .a_i      (fwd_rs1),
        .b_i      (fwd_rs2),
        .flush_i  (flush_i),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_res)
    );

    assign stall_o     = md_busy;
    assign res_valid_o = md_en_i ? md_done : (rst_n & valid_i & ~flush_i & (rd_unused == rd_i));
    assign res_o       = md_en_i ? md_res : alu_res;

endmodule

// File: tb/tb_ex_stage_md.sv
// tb/tb_ex_stage_md.sv - directed scoreboard bench for ex_stage_md
module tb_ex_stage_md;

    logic        clk, rst_n, valid_i, flush_i, md_en_i, opr_a_sel_i, opr_b_sel_i;
    logic [3:0]  aluop_i;
    logic [2:0]  mdop_i;
    logic [4:0]  rs1_i, rs2_i, rd_i, fwd_mem_rd_i, fwd_wb_rd_i;
    logic [31:0] pc_i, imm_i, rs1_data_i, rs2_data_i, fwd_mem_data_i, fwd_wb_data_i;
    logic        fwd_mem_en_i, fwd_wb_en_i;
    logic [31:0] res_o, rs2_fwd_o;
    logic        res_valid_o, stall_o;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    ex_stage_md dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i), .md_en_i(md_en_i),
        .aluop_i(aluop_i), .mdop_i(mdop_i), .opr_a_sel_i(opr_a_sel_i), .opr_b_sel_i(opr_b_sel_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .pc_i(pc_i), .imm_i(imm_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .fwd_mem_en_i(fwd_mem_en_i), .fwd_wb_en_i(fwd_wb_en_i),
        .fwd_mem_rd_i(fwd_mem_rd_i), .fwd_wb_rd_i(fwd_wb_rd_i),
        .fwd_mem_data_i(fwd_mem_data_i), .fwd_wb_data_i(fwd_wb_data_i),
        .res_o(res_o), .res_valid_o(res_valid_o), .stall_o(stall_o), .rs2_fwd_o(rs2_fwd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_sb"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) check({tag, "_res"}, res_o, exp_q.pop_front());
    endtask

    task automatic alu_op(input string tag, input logic [3:0] op, input logic [31:0] exp,
                          input logic [31:0] exp_rs2);
        @(posedge clk); #1;
        valid_i = 1'b1; md_en_i = 1'b0; aluop_i = op;
        exp_q.push_back(exp);
        @(negedge clk);
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_valid"}, 32'(res_valid_o), 32'd1);
        check({tag, "_rs2fwd"}, rs2_fwd_o, exp_rs2);
        pop_check(tag);
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic md_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n, stall_cnt;
        bit seen;
        @(posedge clk); #1;
        valid_i = 1'b1; md_en_i = 1'b1; mdop_i = op;
        rs1_i = 5'd1; rs2_i = 5'd2; rs1_data_i = a; rs2_data_i = b;
        exp_q.push_back(exp);
        @(negedge clk);
        check({tag, "_acc_stall"}, 32'(stall_o), 32'd1);
        check({tag, "_acc_valid"}, 32'(res_valid_o), 32'd0);
        stall_cnt = stall_o ? 1 : 0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (res_valid_o) seen = 1'b1;
            else if (stall_o) stall_cnt++;
            else break;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_latency"}, 32'(n), 32'(lat));
            check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(lat));
            check({tag, "_done_stall"}, 32'(stall_o), 32'd0);
            pop_check(tag);
        end else begin
            void'(exp_q.pop_front());
        end
        @(posedge clk); #1;
        valid_i = 1'b0; md_en_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 1'b1; flush_i = 1'b0; md_en_i = 1'b1; aluop_i = 4'd0; mdop_i = 3'd0;
        opr_a_sel_i = 1'b0; opr_b_sel_i = 1'b0; rs1_i = '0; rs2_i = '0; rd_i = 5'd3;
        pc_i = 32'h100; imm_i = 32'h20; rs1_data_i = '0; rs2_data_i = '0;
        fwd_mem_en_i = 1'b0; fwd_wb_en_i = 1'b0; fwd_mem_rd_i = '0; fwd_wb_rd_i = '0;
        fwd_mem_data_i = '0; fwd_wb_data_i = '0;
        #2;
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_valid", 32'(res_valid_o), 32'd0);
        check("rst_res", res_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; valid_i = 1'b0; md_en_i = 1'b0;

        // Forwarding: MEM beats WB, WB used when MEM misses, x0 never forwarded.
        rs1_i = 5'd5; rs1_data_i = 32'hAA; rs2_i = 5'd6; rs2_data_i = 32'h1;
        fwd_mem_en_i = 1'b1; fwd_mem_rd_i = 5'd5; fwd_mem_data_i = 32'h11;
        fwd_wb_en_i = 1'b1; fwd_wb_rd_i = 5'd5; fwd_wb_data_i = 32'h22;
        alu_op("fwd_mem_prio", 4'd0, 32'h12, 32'h1);
        fwd_mem_rd_i = 5'd7;
        alu_op("fwd_wb", 4'd0, 32'h23, 32'h1);
        rs1_i = 5'd0; rs1_data_i = 32'h0; fwd_mem_rd_i = 5'd0; fwd_wb_rd_i = 5'd0;
        alu_op("fwd_x0", 4'd0, 32'h1, 32'h1);
        rs1_i = 5'd1; rs1_data_i = 32'h10; fwd_mem_en_i = 1'b0; fwd_wb_rd_i = 5'd6; fwd_wb_data_i = 32'h5;
        alu_op("fwd_rs2_sub", 4'd1, 32'hB, 32'h5);
        fwd_wb_en_i = 1'b0; opr_a_sel_i = 1'b1; opr_b_sel_i = 1'b1;
        alu_op("pc_imm", 4'd0, 32'h120, 32'h1);
        opr_a_sel_i = 1'b0; opr_b_sel_i = 1'b0;

        md_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3);
        md_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
        md_op("mul_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 3);
        md_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 3);
        md_op("divu_zero", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        md_op("rem_zero", 3'd6, 32'd5, 32'd0, 32'd5, 1);
        md_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        md_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        md_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        md_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        md_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        md_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);

        // Flush in the tenth divide cycle: no result, FSM back to idle.
        @(posedge clk); #1;
        valid_i = 1'b1; md_en_i = 1'b1; mdop_i = 3'd5; rs1_data_i = 32'd100; rs2_data_i = 32'd7;
        @(negedge clk);
        check("flush_acc_stall", 32'(stall_o), 32'd1);
        repeat (10) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        check("flush_stall", 32'(stall_o), 32'd0);
        check("flush_valid", 32'(res_valid_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_flush_stall", 32'(stall_o), 32'd0);
            check("post_flush_valid", 32'(res_valid_o), 32'd0);
        end
        md_en_i = 1'b0;
        rs1_i = 5'd1; rs2_i = 5'd2; rs1_data_i = 32'h0F0; rs2_data_i = 32'h00F;
        alu_op("post_flush_or", 4'd8, 32'h0FF, 32'h00F);

        // Asynchronous reset in the fifth divide cycle.
        @(posedge clk); #1;
        valid_i = 1'b1; md_en_i = 1'b1; mdop_i = 3'd4; rs1_data_i = 32'hFFFF_FFF9; rs2_data_i = 32'd2;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_stall", 32'(stall_o), 32'd0);
        check("arst_valid", 32'(res_valid_o), 32'd0);
        check("arst_res", res_o, 32'd0);
        @(posedge clk); #1;
        valid_i = 1'b0; rst_n = 1'b1;
        md_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12, 3);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
